// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I ALU decode-and-issue stage with 2-entry elastic output buffer
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_mode,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [3:0] MODE_NOP = 4'd0;
  localparam logic [3:0] MODE_ADD = 4'd1;
  localparam logic [3:0] MODE_SUB = 4'd2;
  localparam logic [3:0] MODE_AND = 4'd3;
  localparam logic [3:0] MODE_OR  = 4'd4;
  localparam logic [3:0] MODE_XOR = 4'd5;
  localparam logic [3:0] MODE_SLL = 4'd6;
  localparam logic [3:0] MODE_SRL = 4'd7;
  localparam logic [3:0] MODE_SRA = 4'd8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // One buffered issue slot: mode, A, B, rd, illegal flag
  typedef struct packed {
    logic [3:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm;
  logic        unused_rs1_field;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm    = {{20{in_instr[31]}}, in_instr[31:20]};
  // The rs1 register-number field is consumed upstream; only its value arrives here
  assign unused_rs1_field = ^in_instr[19:15];

  logic [3:0] op_mode;
  logic       op_ok;
  logic       op_shift;
  entry_t     dec;

  // Decode the instruction into an ALU mode and operands; unsupported forms become NOP/illegal
  always_comb begin
    op_mode  = MODE_NOP;
    op_ok    = 1'b0;
    op_shift = 1'b0;
    dec      = '0;
    if (opcode == OP_R || opcode == OP_I) begin
      case (f3)
        3'b000: begin
          if (opcode == OP_I || f7 == F7_STD) begin
            op_mode = MODE_ADD;
            op_ok   = 1'b1;
          end else if (f7 == F7_ALT) begin
            op_mode = MODE_SUB;
            op_ok   = 1'b1;
          end
        end
        3'b001: begin
          op_shift = 1'b1;
          if (f7 == F7_STD) begin
            op_mode = MODE_SLL;
            op_ok   = 1'b1;
          end
        end
        3'b100: begin
          if (opcode == OP_I || f7 == F7_STD) begin
            op_mode = MODE_XOR;
            op_ok   = 1'b1;
          end
        end
        3'b110: begin
          if (opcode == OP_I || f7 == F7_STD) begin
            op_mode = MODE_OR;
            op_ok   = 1'b1;
          end
        end
        3'b111: begin
          if (opcode == OP_I || f7 == F7_STD) begin
            op_mode = MODE_AND;
            op_ok   = 1'b1;
          end
        end
        3'b101: begin
          op_shift = 1'b1;
          if (f7 == F7_STD) begin
            op_mode = MODE_SRL;
            op_ok   = 1'b1;
          end else if (f7 == F7_ALT) begin
            op_mode = MODE_SRA;
            op_ok   = 1'b1;
          end
        end
        default: begin
          // SLT/SLTU have no ALU mode
          op_ok = 1'b0;
        end
      endcase
    end

    dec.rd = in_instr[11:7];
    if (op_ok) begin
      dec.mode    = op_mode;
      dec.a       = in_rs1;
      dec.illegal = 1'b0;
      if (opcode == OP_R) begin
        dec.b = op_shift ? {27'b0, in_rs2[4:0]} : in_rs2;
      end else begin
        dec.b = op_shift ? {27'b0, in_instr[24:20]} : imm;
      end
    end else begin
      dec.mode    = MODE_NOP;
      dec.a       = '0;
      dec.b       = '0;
      dec.illegal = 1'b1;
    end
  end

  state_t state, state_n;
  entry_t main_q, skid_q;
  logic   accept, pop;
  logic   load_main_dec, load_main_skid, load_skid;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != S_EMPTY);
  assign pop       = out_valid & out_ready;

  // Buffer occupancy transitions and which register loads from where
  always_comb begin
    state_n        = state;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          state_n       = S_ONE;
          load_main_dec = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          load_main_dec = 1'b1;
        end else if (accept) begin
          state_n   = S_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_n = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_n        = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_n = S_EMPTY;
      end
    endcase
  end

  // State register; in_ready is registered from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != S_FULL);
    end
  end

  // Main (head) register feeding the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (load_main_dec) begin
      main_q <= dec;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  // Skid register absorbing the one op accepted after the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= dec;
    end
  end

  assign out_mode    = main_q.mode;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_mode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic [73:0] sb[$];
  logic last_acc;
  logic last_pop;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [73:0] got, input logic [73:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [73:0] mk(input logic [3:0] m, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] rd, input logic ill);
    return {m, a, b, rd, ill};
  endfunction

  function automatic logic [73:0] obs();
    return {out_mode, out_a, out_b, out_rd, out_illegal};
  endfunction

  // Reference decoder: mode 0 from the table means the op is illegal
  function automatic logic [73:0] model(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] m;
    logic [31:0] b;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    m  = 4'd0;
    if (op == 7'h33) begin
      if (f3 == 3'd0 && f7 == 7'h00) m = 4'd1;
      if (f3 == 3'd0 && f7 == 7'h20) m = 4'd2;
      if (f3 == 3'd1 && f7 == 7'h00) m = 4'd6;
      if (f3 == 3'd4 && f7 == 7'h00) m = 4'd5;
      if (f3 == 3'd6 && f7 == 7'h00) m = 4'd4;
      if (f3 == 3'd7 && f7 == 7'h00) m = 4'd3;
      if (f3 == 3'd5 && f7 == 7'h00) m = 4'd7;
      if (f3 == 3'd5 && f7 == 7'h20) m = 4'd8;
      b = (f3 == 3'd1 || f3 == 3'd5) ? (rs2 & 32'h1f) : rs2;
    end else begin
      if (op == 7'h13) begin
        if (f3 == 3'd0) m = 4'd1;
        if (f3 == 3'd4) m = 4'd5;
        if (f3 == 3'd6) m = 4'd4;
        if (f3 == 3'd7) m = 4'd3;
        if (f3 == 3'd1 && f7 == 7'h00) m = 4'd6;
        if (f3 == 3'd5 && f7 == 7'h00) m = 4'd7;
        if (f3 == 3'd5 && f7 == 7'h20) m = 4'd8;
      end
      b = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
    end
    if (m == 4'd0) return mk(4'd0, 32'd0, 32'd0, ins[11:7], 1'b1);
    return mk(m, rs1, b, ins[11:7], 1'b0);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 3);
    if (sel < 2) w[6:0] = 7'h33;
    else if (sel == 2) w[6:0] = 7'h13;
    else w[1:0] = 2'b11;
    sel = $urandom_range(0, 2);
    if (sel == 0) w[31:25] = 7'h00;
    else if (sel == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, then wait for the next negedge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic ordy, input logic [73:0] exp);
    in_valid  = v;
    in_instr  = ins;
    in_rs1    = rs1;
    in_rs2    = rs2;
    out_ready = ordy;
    #1;
    last_acc = 1'b0;
    last_pop = 1'b0;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", out_valid, 1'b0);
      end else if (out_ready) begin
        check("issue", obs(), sb.pop_front());
        last_pop = 1'b1;
      end else begin
        check("hold", obs(), sb[0]);
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(exp);
      last_acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2, input logic [73:0] exp);
    int n;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 6) begin
      cycle(1'b1, ins, rs1, rs2, 1'b1, exp);
      n++;
    end
    if (!last_acc) check("send_timeout", last_acc, 1'b1);
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while (sb.size() > 0 && cycles < 10) begin
      cycle(1'b0, $urandom, $urandom, $urandom, 1'b1, '0);
      cycles++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    #1;
    check("drained_idle", out_valid, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int acc;
    int idx;
    logic [31:0] ops [4];
    logic [31:0] r1 [4];
    logic [31:0] r2 [4];
    logic [31:0] w, a, b;

    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = $urandom; in_instr = $urandom; in_rs1 = $urandom; in_rs2 = $urandom; out_ready = $urandom;
    end
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", obs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, $urandom, $urandom, 1'b1, '0);
    #1;
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);
    @(negedge clk);

    send(32'h40208033, 32'd10, 32'd3, mk(4'd2, 32'd10, 32'd3, 5'd0, 1'b0));
    send(32'hFFF08293, 32'd7, 32'h5555, mk(4'd1, 32'd7, 32'hFFFFFFFF, 5'd5, 1'b0));
    send(32'h4040D293, 32'h80000000, 32'h1234, mk(4'd8, 32'h80000000, 32'd4, 5'd5, 1'b0));
    send(32'h002091B3, 32'hDEADBEEF, 32'h23, mk(4'd6, 32'hDEADBEEF, 32'd3, 5'd3, 1'b0));
    send(32'h0020A033, 32'd9, 32'd9, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b1));
    send(32'h0000A303, 32'd9, 32'd9, mk(4'd0, 32'd0, 32'd0, 5'd6, 1'b1));
    send(32'h40209293, 32'd9, 32'd9, mk(4'd0, 32'd0, 32'd0, 5'd5, 1'b1));
    drain(dc);

    acc = 0;
    for (int i = 0; i < 24; i++) begin
      w = rand_instr(); a = $urandom; b = $urandom;
      cycle(1'b1, w, a, b, 1'b1, model(w, a, b));
      if (last_acc) acc++;
    end
    check("throughput_accepts", acc, 24);
    drain(dc);

    for (int i = 0; i < 4; i++) begin
      ops[i] = rand_instr(); r1[i] = $urandom; r2[i] = $urandom;
    end
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ops[idx], r1[idx], r2[idx], 1'b0, model(ops[idx], r1[idx], r2[idx]));
      if (last_acc) idx++;
    end
    check("bp_accepted", idx, 2);
    #1;
    check("bp_in_ready", in_ready, 1'b0);
    @(negedge clk);
    drain(dc);
    check("bp_drain_cycles", dc, 2);
    while (idx < 4) begin
      send(ops[idx], r1[idx], r2[idx], model(ops[idx], r1[idx], r2[idx]));
      idx++;
    end
    drain(dc);

    for (int i = 0; i < 2; i++) begin
      w = rand_instr(); a = $urandom; b = $urandom;
      cycle(1'b1, w, a, b, 1'b0, model(w, a, b));
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_in_ready", in_ready, 1'b1);
    check("areset_outputs", obs(), '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = rand_instr(); a = $urandom; b = $urandom;
      send(w, a, b, model(w, a, b));
    end
    drain(dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
